// File: rtl/iir_decim_out.sv
// Output stage after the IIR: keeps one sample in DECIM, shifts and saturates it to OUT_W,
// and buffers it in a first-word-fall-through FIFO for a valid/ready consumer.
module iir_decim_out #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    output logic [OUT_W-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       sat_seen,
    input  logic                       clr_flags
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic signed [WIDTH-1:0] MAX_V = {{(WIDTH-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V = ~MAX_V;

    logic [PW-1:0]    phase_q, phase_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             m_valid_q, m_valid_d;
    logic [OUT_W-1:0] m_data_q, m_data_d;
    logic             overflow_q, overflow_d;
    logic             sat_seen_q, sat_seen_d;
    logic [OUT_W-1:0] mem_q [DEPTH];

    logic signed [WIDTH-1:0] shifted;
    logic [OUT_W-1:0]        scaled;
    logic                    clamp, keep, full, pop, push, drop;

    always_comb begin
        shifted = $signed(din) >>> SHIFT;
        clamp   = 1'b0;
        scaled  = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            clamp  = 1'b1;
            scaled = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            clamp  = 1'b1;
            scaled = MIN_V[OUT_W-1:0];
        end
    end

    // m_valid_q mirrors level!=0, so a pop can never happen on an empty FIFO.
    always_comb begin
        keep = din_valid & (phase_q == '0);
        full = (level_q == LVL_FULL);
        pop  = m_valid_q & m_ready;
        push = keep & (~full | pop);
        drop = keep & full & ~pop;

        phase_d = phase_q;
        if (din_valid)
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        m_valid_d = (level_d != '0);
        // Next head is the incoming sample when it lands exactly where the read pointer goes.
        if (level_d == '0)
            m_data_d = '0;
        else if (push && (wr_ptr_q == rd_ptr_d))
            m_data_d = scaled;
        else
            m_data_d = mem_q[rd_ptr_d];

        overflow_d = drop | (overflow_q & ~clr_flags);
        sat_seen_d = (keep & clamp) | (sat_seen_q & ~clr_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            overflow_q <= 1'b0;
            sat_seen_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            overflow_q <= overflow_d;
            sat_seen_q <= sat_seen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= scaled;
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign sat_seen = sat_seen_q;
endmodule

// File: tb/tb_iir_decim_out.sv
// Directed bench for iir_decim_out: a reference model pushes expected samples into a queue
// and an independent monitor pops and compares on every output handshake.
module tb_iir_decim_out;
    logic        clk, rst;
    logic [31:0] din;
    logic        din_valid, m_ready, clr_flags;
    logic [15:0] m_data;
    logic        m_valid, overflow, sat_seen;
    logic [3:0]  level;

    logic [31:0] s_din;
    logic        s_valid, s_ready, s_clr;
    logic [15:0] s_data;
    logic        s_mvalid, s_ovf, s_sat;
    logic [3:0]  s_level;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    int          mlevel, mphase;

    iir_decim_out #(.WIDTH(32), .OUT_W(16), .SHIFT(0), .DECIM(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
        .overflow(overflow), .sat_seen(sat_seen), .clr_flags(clr_flags));

    iir_decim_out #(.WIDTH(32), .OUT_W(16), .SHIFT(4), .DECIM(1), .DEPTH(8)) dut_s (
        .clk(clk), .rst(rst), .din(s_din), .din_valid(s_valid),
        .m_data(s_data), .m_valid(s_mvalid), .m_ready(s_ready), .level(s_level),
        .overflow(s_ovf), .sat_seen(s_sat), .clr_flags(s_clr));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] sat16(input logic signed [31:0] d);
        if (d > 32767) return 16'h7fff;
        if (d < -32768) return 16'h8000;
        return d[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] d);
        din_valid = v;
        din = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: decimation phase, occupancy and drop decisions.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            mlevel = 0;
            mphase = 0;
        end else begin
            automatic bit k  = din_valid && (mphase == 0);
            automatic bit po = m_ready && (mlevel != 0);
            automatic bit pu = k && (mlevel < 8 || po);
            if (pu) exp_q.push_back(sat16(din));
            mlevel = mlevel + int'(pu) - int'(po);
            if (din_valid) mphase = (mphase + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL stream: unexpected output %0h with nothing expected", m_data);
            end else begin
                chk("stream", {16'h0, m_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; m_ready = 1'b0; clr_flags = 1'b0;
        s_din = '0; s_valid = 1'b0; s_ready = 1'b1; s_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", {31'h0, m_valid}, 0);
        chk("rst_level", {28'h0, level}, 0);
        chk("rst_m_data", {16'h0, m_data}, 0);
        chk("rst_overflow", {31'h0, overflow}, 0);
        chk("rst_sat_seen", {31'h0, sat_seen}, 0);
        rst = 1'b0;

        // 1: stream decimation
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, i);
            if (i == 0) begin
                chk("lat_m_valid", {31'h0, m_valid}, 1);
                chk("lat_m_data", {16'h0, m_data}, 0);
            end
        end
        repeat (3) cyc(1'b0, 0);
        chk("t1_overflow", {31'h0, overflow}, 0);
        chk("t1_sat_seen", {31'h0, sat_seen}, 0);
        chk("t1_level", {28'h0, level}, 0);

        // 2: saturation
        cyc(1'b1, 40000);
        chk("sat_pos", {16'h0, m_data}, 32'h7fff);
        chk("sat_seen", {31'h0, sat_seen}, 1);
        repeat (3) cyc(1'b1, 0);
        cyc(1'b1, -40000);
        chk("sat_neg", {16'h0, m_data}, 32'h8000);
        repeat (3) cyc(1'b1, 0);
        cyc(1'b1, -5);
        chk("neg_small", {16'h0, m_data}, 32'hfffb);
        repeat (3) cyc(1'b1, 0);
        s_valid = 1'b1; s_din = 40000;
        cyc(1'b0, 0);
        chk("shift4_pos", {16'h0, s_data}, 2500);
        chk("shift4_nosat", {31'h0, s_sat}, 0);
        s_din = -40000;
        cyc(1'b0, 0);
        chk("shift4_neg", {16'h0, s_data}, 32'hf63c);
        s_din = 32'h0010_0000;
        cyc(1'b0, 0);
        chk("shift4_clamp", {16'h0, s_data}, 32'h7fff);
        chk("shift4_sat", {31'h0, s_sat}, 1);
        s_valid = 1'b0;

        // 3: backpressure with overflow
        m_ready = 1'b0;
        for (int i = 0; i < 40; i++) cyc(1'b1, i);
        chk("bp_level", {28'h0, level}, 8);
        chk("bp_overflow", {31'h0, overflow}, 1);
        chk("bp_head", {16'h0, m_data}, 0);
        m_ready = 1'b1;
        repeat (12) cyc(1'b0, 0);
        chk("bp_drained_valid", {31'h0, m_valid}, 0);
        chk("bp_drained_level", {28'h0, level}, 0);
        chk("bp_empty_data", {16'h0, m_data}, 0);

        // 4: push and pop together while full
        clr_flags = 1'b1;
        cyc(1'b0, 0);
        clr_flags = 1'b0;
        chk("clr_overflow", {31'h0, overflow}, 0);
        m_ready = 1'b0;
        for (int i = 0; i < 32; i++) cyc(1'b1, 100 + i);
        chk("full_level", {28'h0, level}, 8);
        m_ready = 1'b1;
        cyc(1'b1, 200);
        chk("full_pp_level", {28'h0, level}, 8);
        chk("full_pp_overflow", {31'h0, overflow}, 0);
        chk("full_pp_head", {16'h0, m_data}, 104);
        repeat (10) cyc(1'b0, 0);
        chk("full_pp_drained", {28'h0, level}, 0);

        // 5: async reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1000 + i);
        chk("pre_rst_level", {28'h0, level}, 5);
        din_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_m_valid", {31'h0, m_valid}, 0);
        chk("async_level", {28'h0, level}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_ready = 1'b1;
        cyc(1'b1, 7);
        chk("post_rst_first", {16'h0, m_data}, 7);
        for (int i = 8; i < 12; i++) cyc(1'b1, i);
        chk("post_rst_next", {16'h0, m_data}, 11);
        repeat (3) cyc(1'b0, 0);

        // 6: flag clear against a same-cycle drop, then a plain clear
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 36; i++) cyc(1'b1, (i == 0) ? 40000 : i);
        chk("f_level", {28'h0, level}, 8);
        chk("f_overflow", {31'h0, overflow}, 1);
        chk("f_sat_seen", {31'h0, sat_seen}, 1);
        clr_flags = 1'b1;
        cyc(1'b1, 36);
        chk("clr_vs_drop", {31'h0, overflow}, 1);
        chk("clr_vs_drop_level", {28'h0, level}, 8);
        cyc(1'b0, 0);
        clr_flags = 1'b0;
        chk("clr_overflow2", {31'h0, overflow}, 0);
        chk("clr_sat_seen", {31'h0, sat_seen}, 0);
        m_ready = 1'b1;
        repeat (12) cyc(1'b0, 0);
        chk("end_level", {28'h0, level}, 0);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
